// File: rtl/powlib_sfifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on both ends.
// Storage is an unreset RAM with a combinational read; flags decode only the registered count.
module powlib_sfifo #(
    parameter int W    = 32,
    parameter int D    = 8,
    parameter int AFT  = D - 1,
    parameter int WIDX = $clog2(D),
    parameter int WCNT = $clog2(D + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    wrdata,
    input  logic            wrvld,
    output logic            wrrdy,
    output logic [W-1:0]    rddata,
    output logic            rdvld,
    input  logic            rdrdy,
    output logic [WCNT-1:0] cnt,
    output logic            amfull
);

    localparam logic [WCNT-1:0] FULLCNT = WCNT'(D);
    localparam logic [WCNT-1:0] AFTCNT  = WCNT'(AFT);
    localparam logic [WIDX-1:0] LASTPTR = WIDX'(D - 1);

    logic [W-1:0]    mem [D];
    logic [WIDX-1:0] wrptr;
    logic [WIDX-1:0] rdptr;
    logic            wracc;
    logic            rdacc;

    // Flags come from the registered count only, so wrvld/rdrdy never reach them.
    assign wrrdy  = (cnt != FULLCNT);
    assign rdvld  = (cnt != '0);
    assign amfull = (cnt >= AFTCNT);
    assign rddata = mem[rdptr];

    assign wracc = wrvld && wrrdy;
    assign rdacc = rdvld && rdrdy;

    // Explicit wrap so depths that are not a power of two cycle correctly.
    function automatic logic [WIDX-1:0] advance(input logic [WIDX-1:0] ptr);
        return (ptr == LASTPTR) ? '0 : ptr + WIDX'(1);
    endfunction

    // NOTE: the storage array is deliberately not reset; resetting the pointers and count
    // is enough to make old words unreachable, and it keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (!rst && wracc) begin
            mem[wrptr] <= wrdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr <= '0;
            rdptr <= '0;
            cnt   <= '0;
        end else begin
            if (wracc) begin
                wrptr <= advance(wrptr);
            end
            if (rdacc) begin
                rdptr <= advance(rdptr);
            end
            case ({wracc, rdacc})
                2'b10:   cnt <= cnt + WCNT'(1);
                2'b01:   cnt <= cnt - WCNT'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_powlib_sfifo.sv
// Self-checking bench for powlib_sfifo: a vector table on a D=8 instance, hand-written
// corner sequences, and a randomized D=5 stream, all scored against queue-based models.
module tb_powlib_sfifo;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W-1:0] wd8, rd8;
    logic         wv8, wy8, rv8, rr8, af8;
    logic [3:0]   c8;

    logic [W-1:0] wd5, rd5;
    logic         wv5, wy5, rv5, rr5, af5;
    logic [2:0]   c5;

    powlib_sfifo #(.W(W), .D(8)) dut8 (
        .clk(clk), .rst(rst),
        .wrdata(wd8), .wrvld(wv8), .wrrdy(wy8),
        .rddata(rd8), .rdvld(rv8), .rdrdy(rr8),
        .cnt(c8), .amfull(af8)
    );

    powlib_sfifo #(.W(W), .D(5)) dut5 (
        .clk(clk), .rst(rst),
        .wrdata(wd5), .wrvld(wv5), .wrrdy(wy5),
        .rddata(rd5), .rdvld(rv5), .rdrdy(rr5),
        .cnt(c5), .amfull(af5)
    );

    // Reference models: the FIFO contents as plain queues, oldest word at index 0.
    logic [W-1:0] q8[$];
    logic [W-1:0] q5[$];

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          rst;
        bit          wv;
        logic [31:0] wd;
        bit          rr;
        int          cnt;
        bit          wrrdy;
        bit          rdvld;
        bit          amfull;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit wv, logic [31:0] wd, bit rr, int c,
                                bit wy, bit rv, bit af, logic [31:0] rd);
        vec_t v;
        v.rst = r; v.wv = wv; v.wd = wd; v.rr = rr; v.cnt = c;
        v.wrrdy = wy; v.rdvld = rv; v.amfull = af; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model acceptance from the pre-edge model state, then settle past the edge.
    task automatic tick();
        bit a8w, a8r, a5w, a5r;
        logic [W-1:0] d8, d5;
        a8w = wv8 && (q8.size() != 8);
        a8r = rr8 && (q8.size() != 0);
        a5w = wv5 && (q5.size() != 5);
        a5r = rr5 && (q5.size() != 0);
        d8  = wd8;
        d5  = wd5;
        @(posedge clk);
        if (rst) begin
            q8.delete();
            q5.delete();
        end else begin
            if (a8r) void'(q8.pop_front());
            if (a8w) q8.push_back(d8);
            if (a5r) void'(q5.pop_front());
            if (a5w) q5.push_back(d5);
        end
        #1;
    endtask

    task automatic chk8(input string tag);
        check({tag, " cnt8"},    32'(c8),  32'(q8.size()));
        check({tag, " wrrdy8"},  32'(wy8), 32'(q8.size() != 8));
        check({tag, " rdvld8"},  32'(rv8), 32'(q8.size() != 0));
        check({tag, " amfull8"}, 32'(af8), 32'(q8.size() >= 7));
        if (q8.size() != 0) check({tag, " rddata8"}, rd8, q8[0]);
    endtask

    task automatic chk5(input string tag);
        check({tag, " cnt5"},    32'(c5),  32'(q5.size()));
        check({tag, " wrrdy5"},  32'(wy5), 32'(q5.size() != 5));
        check({tag, " rdvld5"},  32'(rv5), 32'(q5.size() != 0));
        check({tag, " amfull5"}, 32'(af5), 32'(q5.size() >= 4));
        if (q5.size() != 0) check({tag, " rddata5"}, rd5, q5[0]);
    endtask

    initial begin
        int nwr;
        int nrd;
        bit wacc;

        rst = 1'b1;
        wv8 = 1'b0; wd8 = '0; rr8 = 1'b0;
        wv5 = 1'b0; wd5 = '0; rr5 = 1'b0;

        // Fill 0..7, full rejection, drain, then the empty-latency word.
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 1, 32'(k - 1), 0, k, k != 8, 1, k >= 7, 0));
        vecs.push_back(mk(0, 1, 32'h99, 1, 7, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 32'h99, 0, 8, 0, 1, 1, 1));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 0, 0, 1, 8 - i, 1, i != 8, (8 - i) >= 7,
                              (i <= 6) ? 32'(i + 1) : 32'h99));
        vecs.push_back(mk(0, 1, 32'hA5A5A5A5, 0, 1, 1, 1, 0, 32'hA5A5A5A5));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));

        tick();
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            wv8 = vecs[i].wv;
            wd8 = vecs[i].wd;
            rr8 = vecs[i].rr;
            tick();
            check($sformatf("vec%0d cnt", i),    32'(c8),  32'(vecs[i].cnt));
            check($sformatf("vec%0d wrrdy", i),  32'(wy8), 32'(vecs[i].wrrdy));
            check($sformatf("vec%0d rdvld", i),  32'(rv8), 32'(vecs[i].rdvld));
            check($sformatf("vec%0d amfull", i), 32'(af8), 32'(vecs[i].amfull));
            if (vecs[i].rdvld) check($sformatf("vec%0d rddata", i), rd8, vecs[i].rd);
        end
        wv8 = 1'b0; rr8 = 1'b0;

        // Simultaneous read and write at cnt = 3 for 10 cycles.
        for (int i = 0; i < 3; i++) begin
            wv8 = 1'b1; wd8 = 32'h200 + 32'(i);
            tick();
        end
        check("pre-simul cnt", 32'(c8), 32'd3);
        for (int i = 0; i < 10; i++) begin
            wv8 = 1'b1; wd8 = 32'h300 + 32'(i); rr8 = 1'b1;
            tick();
            check("simul cnt", 32'(c8), 32'd3);
            check("simul head", rd8, (i < 2) ? 32'h201 + 32'(i) : 32'h300 + 32'(i - 2));
            chk8("simul");
        end
        rr8 = 1'b0;

        // Mid-operation reset at cnt = 4 with both handshakes active.
        wv8 = 1'b1; wd8 = 32'h400;
        tick();
        check("pre-reset cnt", 32'(c8), 32'd4);
        rst = 1'b1; wv8 = 1'b1; rr8 = 1'b1; wd8 = 32'h401;
        tick();
        rst = 1'b0;
        check("reset cnt",   32'(c8),  32'd0);
        check("reset rdvld", 32'(rv8), 32'd0);
        check("reset wrrdy", 32'(wy8), 32'd1);
        check("reset amfull", 32'(af8), 32'd0);
        wv8 = 1'b1; wd8 = 32'h55; rr8 = 1'b0;
        tick();
        wv8 = 1'b0;
        check("post-reset rdvld", 32'(rv8), 32'd1);
        check("post-reset first", rd8, 32'h55);
        chk8("post-reset");
        rr8 = 1'b1;
        tick();
        rr8 = 1'b0;
        chk8("post-reset drain");

        // Randomized D=5 stream of 0x100..0x113 with reader backpressure.
        nwr = 0;
        nrd = 0;
        for (int cyc = 0; cyc < 600 && nrd < 20; cyc++) begin
            wv5 = (nwr < 20);
            wd5 = 32'h100 + 32'(nwr);
            rr5 = (cyc >= 8) && ($urandom_range(0, 2) != 0);
            wacc = wv5 && wy5;
            if (rv5 && rr5) begin
                check("stream order", rd5, 32'h100 + 32'(nrd));
                nrd++;
            end
            tick();
            if (wacc) nwr++;
            chk5("stream");
        end
        wv5 = 1'b0; rr5 = 1'b0;
        check("stream words read", 32'(nrd), 32'd20);
        tick();
        check("stream empty after", 32'(rv5), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
